// File: rtl/rect_fill_pkg.sv
// Shared screen geometry, coordinate widths and FSM encoding for the rect_fill display path.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: SCREEN_W/SCREEN_H, X_W/Y_W/COLOUR_W, and state_t with S_IDLE/S_DRAW/S_DONE.
package rect_fill_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_clip.sv
// Clips a rectangle (origin + size) to the screen, giving inclusive end coordinates.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: x0/y0/w/h in; x_end/y_end (clipped inclusive corner), empty (nothing to draw) out.
module rect_clip
  import rect_fill_pkg::*;
(
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] x_end,
  output logic [Y_W-1:0] y_end,
  output logic           empty
);

  // One extra bit so origin+size cannot wrap before the screen clamp.
  logic [X_W:0] x_far;
  logic [Y_W:0] y_far;

  always_comb begin
    x_far = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
    y_far = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);
    x_end = (x_far > (X_W+1)'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : x_far[X_W-1:0];
    y_end = (y_far > (Y_W+1)'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : y_far[Y_W-1:0];
    // Ends are meaningless when empty (zero size underflows); callers must check this first.
    empty = (w == '0) || (h == '0) ||
            (x0 >= X_W'(SCREEN_W)) || (y0 >= Y_W'(SCREEN_H));
  end

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: accepts one clipped rectangle command and emits one pixel per clock in raster order.
// Latency: first plot one cycle after start is accepted; done one cycle after the last plot.
// Backpressure: none downstream; start is only accepted in IDLE and is dropped (not queued) while busy.
// Ports: clock/resetn; start,x0,y0,w,h,colour_in command in; busy,done status out; x,y,colour,plot to vga_adapter.
module rect_fill
  import rect_fill_pkg::*;
(
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      w,
  input  logic [Y_W-1:0]      h,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot
);

  state_t state_q, state_d;

  logic [X_W-1:0]      x0_q, x0_d;
  logic [X_W-1:0]      x_end_q, x_end_d;
  logic [Y_W-1:0]      y_end_q, y_end_d;
  logic [X_W-1:0]      x_d;
  logic [Y_W-1:0]      y_d;
  logic [COLOUR_W-1:0] colour_d;
  logic                plot_d, busy_d, done_d;

  logic [X_W-1:0]      clip_x_end;
  logic [Y_W-1:0]      clip_y_end;
  logic                clip_empty;

  rect_clip u_clip (
    .x0    (x0),
    .y0    (y0),
    .w     (w),
    .h     (h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  // The x/y output registers double as the raster cursor, so the pixel on
  // the adapter bus is always the one being decided on this cycle.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          busy_d  = 1'b1;
          x0_d    = x0;
          x_end_d = clip_x_end;
          y_end_d = clip_y_end;
          if (clip_empty) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x_d      = x0;
            y_d      = y0;
            colour_d = colour_in;
            plot_d   = 1'b1;
            state_d  = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        busy_d = 1'b1;
        if (x == x_end_q) begin
          if (y == y_end_q) begin
            // Last pixel is on the bus now; cursor holds its final value.
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            x_d    = x0_q;
            y_d    = y + Y_W'(1);
            plot_d = 1'b1;
          end
        end else begin
          x_d    = x + X_W'(1);
          plot_d = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      plot    <= plot_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_fill.sv
module tb_rect_fill;
  import rect_fill_pkg::*;

  logic                clock;
  logic                resetn;
  logic                start;
  logic [X_W-1:0]      x0;
  logic [Y_W-1:0]      y0;
  logic [X_W-1:0]      w;
  logic [Y_W-1:0]      h;
  logic [COLOUR_W-1:0] colour_in;
  logic                busy, done, plot;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;

  int tests_run = 0;
  int tests_failed = 0;

  // Capture of one command's output stream (cycle 1 = first cycle after accept).
  logic [X_W-1:0]      px[$];
  logic [Y_W-1:0]      py[$];
  logic [COLOUR_W-1:0] pc[$];
  int plot_cnt, first_plot, last_plot, done_cyc, busy_cnt;

  rect_fill dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at #1 after a posedge with the DUT idle. Issues a command and records
  // every cycle up to and including done (bounded). If inj > 0, a different
  // command is pulsed on start during capture cycle inj.
  task automatic run_cmd(input logic [X_W-1:0] ax0, input logic [Y_W-1:0] ay0,
                         input logic [X_W-1:0] aw, input logic [Y_W-1:0] ah,
                         input logic [COLOUR_W-1:0] ac, input int inj);
    int k;
    bit fin;
    px.delete(); py.delete(); pc.delete();
    plot_cnt = 0; first_plot = 0; last_plot = 0; done_cyc = 0; busy_cnt = 0;
    x0 = ax0; y0 = ay0; w = aw; h = ah; colour_in = ac; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 1;
    fin = 1'b0;
    while (!fin && k < 25000) begin
      if (plot) begin
        px.push_back(x); py.push_back(y); pc.push_back(colour);
        plot_cnt++;
        if (first_plot == 0) first_plot = k;
        last_plot = k;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        fin = 1'b1;
      end else begin
        if (k == inj) begin
          start = 1'b1; x0 = 8'd0; y0 = 7'd0; w = 8'd20; h = 7'd20; colour_in = 3'd1;
        end else begin
          start = 1'b0;
        end
        @(posedge clock); #1;
        k++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; colour_in = '0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({x, y, colour, plot, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: x=%0d y=%0d colour=%0d plot=%0b busy=%0b done=%0b, required all 0",
               x, y, colour, plot, busy, done);
    end
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: plot=%0b busy=%0b, required 0/0", plot, busy);
    end
  endtask

  task automatic test_basic;
    logic [X_W-1:0] ex[4];
    logic [Y_W-1:0] ey[4];
    int bad;
    ex = '{8'd10, 8'd11, 8'd10, 8'd11};
    ey = '{7'd20, 7'd20, 7'd21, 7'd21};
    run_cmd(8'd10, 7'd20, 8'd2, 7'd2, 3'd5, 0);
    tests_run++;
    if (plot_cnt !== 4 || first_plot !== 1 || last_plot !== 4) begin
      tests_failed++;
      $display("FAIL basic_plots: count=%0d first=%0d last=%0d, required 4/1/4", plot_cnt, first_plot, last_plot);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= px.size() || px[i] !== ex[i] || py[i] !== ey[i] || pc[i] !== 3'd5) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL basic_coords: %0d of 4 pixels wrong, required (10,20)(11,20)(10,21)(11,21) colour 5", bad);
    end
    tests_run++;
    if (done_cyc !== 5 || busy_cnt !== 5) begin
      tests_failed++;
      $display("FAIL basic_done: done_cycle=%0d busy_cycles=%0d, required 5/5", done_cyc, busy_cnt);
    end
  endtask

  task automatic test_back_to_back;
    // DUT sits in DONE now (done visible); start raised in this cycle must be ignored.
    x0 = 8'd30; y0 = 7'd30; w = 8'd1; h = 7'd1; colour_in = 3'd4; start = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_during_done: plot=%0b busy=%0b done=%0b, required 0/0/0", plot, busy, done);
    end
    // Still high: accepted now, the earliest legal cycle.
    @(posedge clock); #1;
    start = 1'b0;
    tests_run++;
    if (plot !== 1'b1 || x !== 8'd30 || y !== 7'd30 || colour !== 3'd4 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL back_to_back_plot: plot=%0b x=%0d y=%0d colour=%0d busy=%0b, required 1/30/30/4/1",
               plot, x, y, colour, busy);
    end
    @(posedge clock); #1;
    tests_run++;
    if (plot !== 1'b0 || done !== 1'b1 || x !== 8'd30 || y !== 7'd30 || colour !== 3'd4) begin
      tests_failed++;
      $display("FAIL back_to_back_done: plot=%0b done=%0b x=%0d y=%0d colour=%0d, required 0/1/30/30/4",
               plot, done, x, y, colour);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_clip;
    logic [X_W-1:0] ex[4];
    logic [Y_W-1:0] ey[4];
    int bad;
    ex = '{8'd158, 8'd159, 8'd158, 8'd159};
    ey = '{7'd118, 7'd118, 7'd119, 7'd119};
    run_cmd(8'd158, 7'd118, 8'd5, 7'd5, 3'd3, 0);
    tests_run++;
    if (plot_cnt !== 4 || done_cyc !== 5) begin
      tests_failed++;
      $display("FAIL clip_count: count=%0d done_cycle=%0d, required 4/5", plot_cnt, done_cyc);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= px.size() || px[i] !== ex[i] || py[i] !== ey[i] || pc[i] !== 3'd3) bad++;
    for (int i = 0; i < px.size(); i++)
      if (px[i] > 8'd159 || py[i] > 7'd119) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL clip_coords: %0d pixel errors, required 0", bad);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_empty;
    run_cmd(8'd3, 7'd3, 8'd0, 7'd7, 3'd6, 0);
    tests_run++;
    if (plot_cnt !== 0 || done_cyc !== 1 || busy_cnt !== 1) begin
      tests_failed++;
      $display("FAIL empty_w0: plots=%0d done_cycle=%0d busy_cycles=%0d, required 0/1/1", plot_cnt, done_cyc, busy_cnt);
    end
    @(posedge clock); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_idle: busy=%0b done=%0b, required 0/0", busy, done);
    end
    run_cmd(8'd200, 7'd5, 8'd3, 7'd3, 3'd6, 0);
    tests_run++;
    if (plot_cnt !== 0 || done_cyc !== 1) begin
      tests_failed++;
      $display("FAIL empty_offscreen_x: plots=%0d done_cycle=%0d, required 0/1", plot_cnt, done_cyc);
    end
    @(posedge clock); #1;
    run_cmd(8'd4, 7'd120, 8'd3, 7'd0, 3'd6, 0);
    tests_run++;
    if (plot_cnt !== 0 || done_cyc !== 1) begin
      tests_failed++;
      $display("FAIL empty_h0_offscreen_y: plots=%0d done_cycle=%0d, required 0/1", plot_cnt, done_cyc);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full_screen;
    int bad;
    run_cmd(8'd0, 7'd0, 8'd160, 7'd120, 3'd7, 0);
    tests_run++;
    if (plot_cnt !== 19200 || first_plot !== 1 || last_plot !== 19200) begin
      tests_failed++;
      $display("FAIL full_count: count=%0d first=%0d last=%0d, required 19200/1/19200", plot_cnt, first_plot, last_plot);
    end
    tests_run++;
    if (done_cyc !== 19201) begin
      tests_failed++;
      $display("FAIL full_done: done_cycle=%0d, required 19201", done_cyc);
    end
    bad = 0;
    for (int i = 0; i < px.size(); i++)
      if (px[i] !== X_W'(i % 160) || py[i] !== Y_W'(i / 160)) bad++;
    tests_run++;
    if (bad !== 0 || px.size() == 0 || px[px.size()-1] !== 8'd159 || py[py.size()-1] !== 7'd119) begin
      tests_failed++;
      $display("FAIL full_raster: %0d out-of-order pixels, required 0 ending at (159,119)", bad);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_start_ignored;
    logic [X_W-1:0] ex[6];
    logic [Y_W-1:0] ey[6];
    int bad;
    ex = '{8'd50, 8'd51, 8'd52, 8'd50, 8'd51, 8'd52};
    ey = '{7'd60, 7'd60, 7'd60, 7'd61, 7'd61, 7'd61};
    run_cmd(8'd50, 7'd60, 8'd3, 7'd2, 3'd6, 2);
    tests_run++;
    if (plot_cnt !== 6 || done_cyc !== 7) begin
      tests_failed++;
      $display("FAIL ignore_count: count=%0d done_cycle=%0d, required 6/7", plot_cnt, done_cyc);
    end
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= px.size() || px[i] !== ex[i] || py[i] !== ey[i] || pc[i] !== 3'd6) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ignore_coords: %0d of 6 pixels wrong, required original 3x2 at (50,60) colour 6", bad);
    end
    @(posedge clock); #1;
    tests_run++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_not_queued: busy=%0b plot=%0b, required 0/0", busy, plot);
    end
  endtask

  task automatic test_reset_mid_draw;
    int seen;
    seen = 0;
    x0 = 8'd5; y0 = 7'd5; w = 8'd4; h = 7'd4; colour_in = 3'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (plot) seen++;
    repeat (2) begin
      @(posedge clock); #1;
      if (plot) seen++;
    end
    #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if (seen !== 3 || {x, y, colour, plot, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_draw: plots_before=%0d x=%0d y=%0d colour=%0d plot=%0b busy=%0b done=%0b, required 3 then all 0",
               seen, x, y, colour, plot, busy, done);
    end
    repeat (2) @(posedge clock);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;
    tests_run++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_resume: plot=%0b busy=%0b, required 0/0", plot, busy);
    end
    run_cmd(8'd1, 7'd1, 8'd1, 7'd1, 3'd2, 0);
    tests_run++;
    if (plot_cnt !== 1 || done_cyc !== 2 || px.size() != 1 ||
        px[0] !== 8'd1 || py[0] !== 7'd1 || pc[0] !== 3'd2) begin
      tests_failed++;
      $display("FAIL after_reset_cmd: count=%0d done_cycle=%0d, required single plot (1,1) colour 2 and done 2",
               plot_cnt, done_cyc);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_clip();
    test_empty();
    test_full_screen();
    test_start_ignored();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
